// File: rtl/keypad_scanner_if.sv
// Key event handshake between the keypad scanner and its consumer.
//   key         key code at the event FIFO head (r*COLS + c)
//   key_valid   FIFO non-empty; key/key_release are valid
//   key_ready   consumer accepts the head when key_valid && key_ready
//   key_release head event is a release (always 0 unless release events are built in)
interface keypad_scanner_if #(
  parameter int unsigned KW = 4
) ();
  logic [KW-1:0] key;
  logic          key_valid;
  logic          key_ready;
  logic          key_release;

  modport master (output key, key_valid, key_release, input key_ready);
  modport slave  (input key, key_valid, key_release, output key_ready);
endinterface

// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix keypad scanner. Drives one column low per scan step, samples the
// active-low rows through a 2-flop synchroniser, debounces every key individually and
// queues key events in a FIFO read over the kbus valid/ready handshake.
//   clk        system clock
//   reset      synchronous, active-low reset
//   row        row lines, active-low, asynchronous to clk
//   column     active-low one-hot column drive
//   keys_held  debounced pressed map, bit r*COLS+c
//   kbus       key event handshake (master side)
// Build option: define KEYPAD_RELEASE_EVENT_EN to also queue release events.
module keypad_scanner #(
  parameter int unsigned ROWS           = 3,
  parameter int unsigned COLS           = 3,
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      column,
  output logic [ROWS*COLS-1:0] keys_held,
  keypad_scanner_if.master     kbus
);

  localparam int unsigned NK = ROWS * COLS;
  localparam int unsigned KW = $clog2(NK);
  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EVENT_EN
  localparam int unsigned EW = KW + 1;
`else
  localparam int unsigned EW = KW;
`endif

  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
  localparam logic [DW-1:0] CNT_MAX  = DW'(DEBOUNCE_SCANS - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);

  logic [ROWS-1:0] row_s1, row_s2;
  logic [TW-1:0]   tick_cnt;
  logic            tick;
  logic [CW-1:0]   col_idx, col_nxt;
  logic [DW-1:0]   cnt [NK];

  logic [KW-1:0]   kidx [ROWS];
  logic [ROWS-1:0] diff, ripe, commit;
  logic            sel_found;
  logic [KW-1:0]   sel_key;
`ifdef KEYPAD_RELEASE_EVENT_EN
  logic            sel_rel;
`endif

  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count, count_after_pop;
  logic            full, push, pop, can_push;
  logic [EW-1:0]   push_data, head_nxt, head_q;
  logic            key_valid_q;

  // Scan step, debounce ripeness, commit selection and FIFO next head
  always_comb begin
    tick      = (tick_cnt == TICK_MAX);
    col_nxt   = (col_idx == COL_MAX) ? '0 : col_idx + CW'(1);
    full      = (count == FULL_CNT);
    pop       = key_valid_q && kbus.key_ready;
    can_push  = !full || pop;
    sel_found = 1'b0;
    sel_key   = '0;
`ifdef KEYPAD_RELEASE_EVENT_EN
    sel_rel   = 1'b0;
`endif
    diff      = '0;
    ripe      = '0;
    commit    = '0;
    for (int r = 0; r < ROWS; r++) begin
      kidx[r] = KW'(r * COLS) + KW'(col_idx);
      diff[r] = (~row_s2[r]) != keys_held[kidx[r]];
      ripe[r] = diff[r] && (cnt[kidx[r]] == CNT_MAX);
`ifdef KEYPAD_RELEASE_EVENT_EN
      if (ripe[r] && !sel_found && can_push) begin
        commit[r] = 1'b1;
        sel_found = 1'b1;
        sel_key   = kidx[r];
        sel_rel   = keys_held[kidx[r]];
      end
`else
      // releases never queue, so they never wait for FIFO space
      if (ripe[r] && keys_held[kidx[r]]) begin
        commit[r] = 1'b1;
      end else if (ripe[r] && !sel_found && can_push) begin
        commit[r] = 1'b1;
        sel_found = 1'b1;
        sel_key   = kidx[r];
      end
`endif
    end
    push = tick && sel_found;
`ifdef KEYPAD_RELEASE_EVENT_EN
    push_data = {sel_rel, sel_key};
`else
    push_data = sel_key;
`endif
    count_after_pop = count - (PW+1)'(pop);
    // head register follows the stored entry unless the FIFO drains to empty
    head_nxt = (count_after_pop == '0) ? push_data : mem[rd_ptr + PW'(pop)];
  end

  // Synchroniser, tick divider, column walk, debounce state and event FIFO
  always_ff @(posedge clk) begin
    if (!reset) begin
      row_s1      <= '1;
      row_s2      <= '1;
      tick_cnt    <= '0;
      col_idx     <= '0;
      column      <= ~COLS'(1);
      keys_held   <= '0;
      for (int k = 0; k < NK; k++) cnt[k] <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      key_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      row_s1   <= row;
      row_s2   <= row_s1;
      tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        col_idx <= col_nxt;
        column  <= ~(COLS'(1) << col_nxt);
        for (int r = 0; r < ROWS; r++) begin
          if (!diff[r]) begin
            cnt[kidx[r]] <= '0;
          end else if (commit[r]) begin
            keys_held[kidx[r]] <= ~keys_held[kidx[r]];
            cnt[kidx[r]]       <= '0;
          end else if (cnt[kidx[r]] != CNT_MAX) begin
            cnt[kidx[r]] <= cnt[kidx[r]] + DW'(1);
          end
        end
      end
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count       <= count_after_pop + (PW+1)'(push);
      key_valid_q <= (count_after_pop != '0) || push;
      head_q      <= head_nxt;
    end
  end

  assign kbus.key       = head_q[KW-1:0];
  assign kbus.key_valid = key_valid_q;
`ifdef KEYPAD_RELEASE_EVENT_EN
  assign kbus.key_release = head_q[KW];
`else
  assign kbus.key_release = 1'b0;
`endif

endmodule
